// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 32-bit memory port. D-side has fixed priority,
// limited by a starvation counter. The memory side is a REQ/ACK handshake with a timeout.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_DONE,
  output logic        I_ERR,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [3:0]  D_BE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_DONE,
  output logic        D_ERR,
  output logic [31:0] D_RDATA,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [3:0]  M_BE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  input  logic        M_ACK,
  input  logic [31:0] M_RDATA
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);
  localparam logic [8:0] TLIM = 9'(TIMEOUT);

  state_t     state;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       grant_d, grant_i, tmo;

  // D wins unless I is waiting and D has already won STARVE_LIMIT times in a row
  assign grant_d = D_REQ && (!I_REQ || (streak < SLIM));
  assign grant_i = !grant_d && I_REQ;
  // tcnt counts busy cycles already completed, so this is the last allowed cycle
  assign tmo     = ({1'b0, tcnt} + 9'd1) == TLIM;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      streak  <= '0;
      tcnt    <= '0;
      I_DONE  <= 1'b0;
      I_ERR   <= 1'b0;
      I_RDATA <= '0;
      D_DONE  <= 1'b0;
      D_ERR   <= 1'b0;
      D_RDATA <= '0;
      M_REQ   <= 1'b0;
      M_WE    <= 1'b0;
      M_BE    <= '0;
      M_ADDR  <= '0;
      M_WDATA <= '0;
    end else begin
      I_DONE <= 1'b0;
      I_ERR  <= 1'b0;
      D_DONE <= 1'b0;
      D_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= BUSY_D;
            M_REQ   <= 1'b1;
            M_WE    <= D_WE;
            M_BE    <= D_BE;
            M_ADDR  <= D_ADDR;
            M_WDATA <= D_WDATA;
            tcnt    <= '0;
            if (I_REQ) streak <= (streak < SLIM) ? streak + 4'd1 : SLIM;
            else       streak <= '0;
          end else if (grant_i) begin
            state   <= BUSY_I;
            M_REQ   <= 1'b1;
            M_WE    <= 1'b0;
            M_BE    <= 4'hF;
            M_ADDR  <= I_ADDR;
            M_WDATA <= '0;
            tcnt    <= '0;
            streak  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // an ACK in the final allowed cycle still counts as success
          if (M_ACK) begin
            M_REQ <= 1'b0;
            state <= RESP;
            if (state == BUSY_I) begin
              I_DONE  <= 1'b1;
              I_RDATA <= M_RDATA;
            end else begin
              D_DONE  <= 1'b1;
              D_RDATA <= M_WE ? 32'h0 : M_RDATA;
            end
          end else if (tmo) begin
            M_REQ <= 1'b0;
            state <= RESP;
            if (state == BUSY_I) begin
              I_ERR   <= 1'b1;
              I_RDATA <= '0;
            end else begin
              D_ERR   <= 1'b1;
              D_RDATA <= '0;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table with a grant/response scoreboard, plus
// hand sequences for starvation, reset mid-access and zero-wait memory.
module tb_mem_port_arbiter;
  localparam int          SL = 4;
  localparam int          TO = 255;
  localparam logic [31:0] K  = 32'h0050_0193;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          lat;
    logic        mute;
  } vec_t;

  typedef struct {
    logic        side;  // 1 = D
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        zw = 1'b0, mute = 1'b0, force_ack = 1'b0, ack_drv = 1'b0;
  int          lat = 0;
  int          n_chk = 0, n_fail = 0;
  exp_t        gq[$], rq[$];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  assign m_ack   = zw ? m_req : (ack_drv | force_ack);
  assign m_rdata = m_addr ^ K;

  mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .CLK(clk), .RESET(reset),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_DONE(i_done), .I_ERR(i_err), .I_RDATA(i_rdata),
    .D_REQ(d_req), .D_WE(d_we), .D_BE(d_be), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_DONE(d_done), .D_ERR(d_err), .D_RDATA(d_rdata),
    .M_REQ(m_req), .M_WE(m_we), .M_BE(m_be), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_ACK(m_ack), .M_RDATA(m_rdata)
  );

  // memory responder: ACK after lat extra cycles of M_REQ, never when muted
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      ack_drv = 1'b0;
      if (m_req && !mute && !zw) begin
        if (wcnt >= lat) begin
          ack_drv = 1'b1;
          wcnt    = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not as required", name);
  endtask

  task automatic quiet(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check(name, 64'({i_done, i_err, d_done, d_err, m_req}), 64'h0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   busy, n_left;
    logic prev;
    lat  = v.lat;
    mute = v.mute;
    if (v.d_req) begin
      e.side = 1'b1; e.we = v.d_we; e.be = v.d_be; e.addr = v.d_addr; e.wdata = v.d_wdata;
      e.err = v.mute;
      e.rdata = (v.mute || v.d_we) ? 32'h0 : (v.d_addr ^ K);
      e.busy = v.mute ? TO : v.lat + 1;
      gq.push_back(e); rq.push_back(e);
    end
    if (v.i_req) begin
      e.side = 1'b0; e.we = 1'b0; e.be = 4'hF; e.addr = v.i_addr; e.wdata = 32'h0;
      e.err = v.mute;
      e.rdata = v.mute ? 32'h0 : (v.i_addr ^ K);
      e.busy = v.mute ? TO : v.lat + 1;
      gq.push_back(e); rq.push_back(e);
    end
    n_left = rq.size();
    i_req = v.i_req; i_addr = v.i_addr;
    d_req = v.d_req; d_we = v.d_we; d_be = v.d_be; d_addr = v.d_addr; d_wdata = v.d_wdata;
    busy = 0;
    prev = m_req;
    for (int c = 0; c < 700 && n_left > 0; c++) begin
      @(negedge clk);
      if (m_req && !prev) begin
        busy = 0;
        if (gq.size() == 0) fail("extra_grant");
        else begin
          e = gq.pop_front();
          check("grant_we",    64'(m_we),    64'(e.we));
          check("grant_be",    64'(m_be),    64'(e.be));
          check("grant_addr",  64'(m_addr),  64'(e.addr));
          check("grant_wdata", 64'(m_wdata), 64'(e.wdata));
        end
      end
      if (m_req) busy++;
      prev = m_req;
      if (i_done | i_err | d_done | d_err) begin
        if (rq.size() == 0) fail("extra_resp");
        else begin
          e = rq.pop_front();
          check("resp_side", 64'(d_done | d_err), 64'(e.side));
          check("resp_flags", e.side ? 64'({d_done, d_err}) : 64'({i_done, i_err}),
                e.err ? 64'h1 : 64'h2);
          check("resp_rdata", e.side ? 64'(d_rdata) : 64'(i_rdata), 64'(e.rdata));
          check("busy_cycles", 64'(busy), 64'(e.busy));
          if (e.side) d_req = 1'b0; else i_req = 1'b0;
          n_left--;
        end
      end
    end
    if (n_left > 0) fail("vector_timeout");
    gq.delete();
    rq.delete();
    i_req = 1'b0; d_req = 1'b0;
    quiet("idle_quiet", 2);
  endtask

  initial begin
    int   g, streak, last, n;
    logic prev, exp_d;
    reset = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;

    //        i_req i_addr         d_req d_we d_be    d_addr         d_wdata        lat mute
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 4'h0,   32'h0,         32'h0,         1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0104, 1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h0000_ABCD, 1, 1'b0};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF,   32'h0000_0300, 32'h0,         0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF,   32'h0000_0400, 32'h0,         0, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0108, 1'b0, 1'b0, 4'h0,   32'h0,         32'h0,         3, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_010C, 1'b1, 1'b0, 4'hF,   32'h0000_0500, 32'h0,         2, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outs", 64'({i_done, i_err, d_done, d_err, m_req, m_we, m_be}), 64'h0);
    check("reset_rdata", {i_rdata, d_rdata}, 64'h0);
    check("reset_maddr", {m_addr, m_wdata}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // starvation: both requesters held high, zero-latency memory
    lat = 0; mute = 1'b0;
    i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
    i_req = 1'b1; d_req = 1'b1;
    g = 0; streak = 0; prev = m_req;
    for (int c = 0; c < 200 && g < 10; c++) begin
      @(negedge clk);
      if (m_req && !prev) begin
        exp_d = (streak < SL);
        check("starve_order", 64'(m_addr), exp_d ? 64'h2000 : 64'h1000);
        streak = exp_d ? ((streak < SL) ? streak + 1 : SL) : 0;
        g++;
      end
      prev = m_req;
    end
    check("starve_grants", 64'(g), 64'd10);
    for (int c = 0; c < 20 && !(i_done | d_done); c++) @(negedge clk);
    check("starve_last_done", 64'({i_done, d_done}), 64'h2);
    i_req = 1'b0; d_req = 1'b0;
    quiet("starve_quiet", 2);

    // reset while BUSY_I, then a late ACK that must be ignored
    mute = 1'b1; i_addr = 32'h0000_3000; i_req = 1'b1;
    for (int c = 0; c < 10 && !m_req; c++) @(negedge clk);
    check("rst_busy_mreq", 64'(m_req), 64'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy_drop", 64'({m_req, i_done, i_err}), 64'h0);
    check("rst_busy_maddr", 64'(m_addr), 64'h0);
    reset = 1'b0; i_req = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("rst_late_ack", 64'({m_req, i_done, i_err, i_rdata}), 64'h0);
    quiet("rst_quiet", 3);
    mute = 1'b0;

    // zero-wait memory: I_DONE every 3 cycles, addresses follow I_ADDR
    zw = 1'b1; i_addr = 32'h0000_4000; i_req = 1'b1;
    last = 0; n = 0; prev = m_req;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      if (m_req && !prev) check("zw_addr", 64'(m_addr), 64'(i_addr));
      prev = m_req;
      if (i_done) begin
        check("zw_rdata", 64'(i_rdata), 64'(i_addr ^ K));
        if (n > 0) check("zw_period", 64'(c - last), 64'd3);
        last = c;
        n++;
        i_addr = i_addr + 32'd4;
      end
    end
    check("zw_count", 64'(n), 64'd5);
    i_req = 1'b0;
    quiet("zw_quiet", 2);
    zw = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 32-bit memory port between the CPU's instruction-fetch requester (I-side, read-only) and load/store requester (D-side, read/write). D-side has fixed priority, bounded by a starvation limit that forces an I-side grant. The memory side uses a variable-latency REQ/ACK handshake. Each requester gets a one-cycle DONE pulse with registered read data, or an ERR pulse on timeout.

Parameters:
STARVE_LIMIT, 4, max consecutive D grants while I_REQ is pending before I is forced (1..15)
TIMEOUT, 255, max cycles M_REQ may wait for M_ACK before abort (1..255)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
I_REQ  in  1  instruction fetch request; held high with I_ADDR stable until I_DONE or I_ERR
I_ADDR  in  32  fetch address
I_DONE  out  1  one-cycle pulse: fetch complete
I_ERR  out  1  one-cycle pulse: fetch timed out
I_RDATA  out  32  fetch data, valid with I_DONE
D_REQ  in  1  data request; held high with D_* stable until D_DONE or D_ERR
D_WE  in  1  1 = store, 0 = load
D_BE  in  4  byte enables
D_ADDR  in  32  data address
D_WDATA  in  32  store data
D_DONE  out  1  one-cycle pulse: access complete
D_ERR  out  1  one-cycle pulse: access timed out
D_RDATA  out  32  load data, valid with D_DONE (0 for stores)
M_REQ  out  1  memory request, held until M_ACK or timeout
M_WE  out  1  memory write enable
M_BE  out  4  memory byte enables
M_ADDR  out  32  memory address
M_WDATA  out  32  memory write data
M_ACK  in  1  memory completion, one cycle
M_RDATA  in  32  memory read data, valid with M_ACK

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP.
- Reset (RESET high at an edge): state IDLE; all outputs 0; streak and timeout counters cleared. Reset mid-transaction drops M_REQ at that edge. No DONE/ERR is issued for the aborted access.
- IDLE: M_ACK is ignored.
  - Grant D if D_REQ and (!I_REQ or streak < STARVE_LIMIT); else grant I if I_REQ.
  - On grant, register M_* from the winner (I grant: M_WE=0, M_BE=4'hF, M_WDATA=0) and set M_REQ=1 at the same edge. Go to BUSY_I or BUSY_D.
- Streak counter, updated at grant:
  - D grant with I_REQ high: streak+1, saturating at STARVE_LIMIT.
  - D grant with I_REQ low: streak=0.
  - I grant: streak=0.
- BUSY_x: M_* held stable; timeout counter increments each cycle.
  - M_ACK high: M_REQ=0, latch M_RDATA into x_RDATA (D stores latch 0), pulse x_DONE next cycle, go RESP.
  - Counter reaches TIMEOUT without M_ACK: M_REQ=0, pulse x_ERR next cycle, x_RDATA=0, go RESP.
  - M_ACK in the same cycle the counter reaches TIMEOUT: treated as success.
- RESP: DONE/ERR high exactly this cycle. REQ inputs are not evaluated. Always returns to IDLE.
- Minimum access: grant edge t, M_REQ high t..; M_ACK in cycle t gives DONE at t+1. Back-to-back grants occur every 3 cycles at zero memory latency.
- Requester may deassert REQ only after DONE/ERR. Dropping REQ mid-access is illegal; the arbiter completes the access regardless.
- x_RDATA holds its value until the next completion on that side.

Test Plan:
- Reset, then I_REQ=1, I_ADDR=0x100, M_ACK one cycle after M_REQ with M_RDATA=0x00500093 -> M_ADDR=0x100, M_WE=0, M_BE=F; I_DONE pulses once; I_RDATA=0x00500093; D_DONE stays 0.
- I_REQ and D_REQ (store, ADDR=0x200, BE=4'b0011, WDATA=0xABCD) both high in IDLE -> D granted first: M_WE=1, M_BE=0011, D_DONE, D_RDATA=0; I granted next, I_DONE after.
- D_REQ and I_REQ held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I.
- M_ACK never asserted on a D load, TIMEOUT=255 -> M_REQ drops after 255 busy cycles; D_ERR pulses once; D_DONE=0; D_RDATA=0; next request served normally.
- RESET asserted while in BUSY_I -> M_REQ=0 at that edge; no I_DONE; M_ACK arriving one cycle later is ignored; state IDLE.
- Zero-wait memory (M_ACK combinationally tied to M_REQ), I_REQ held high -> I_DONE every 3 cycles; addresses track I_ADDR updates.
